dsm_mod2: RTL and testbench

- Second-order, 1-bit delta-sigma modulator.
- Sits directly downstream of the 16-bit signed sine generator in the DSM DAC datapath.
- Latches each new signed sample when the generator's clock-enable fires.
- Runs a CIFB loop on every modulator-enable cycle and emits a 1-bit pulse-density stream that drives the DAC output pin through an external RC filter.

---
 rtl/dsm_mod2.sv | 123 ++++++++++++
 tb/tb_dsm_mod2.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_mod2.sv
// dsm_mod2 -- second-order, 1-bit delta-sigma modulator (CIFB topology).
//
// Latches a signed sample from the upstream sine generator whenever
// sample_en fires. The sample is clamped to +/-LIMIT so the loop stays
// stable. On every mod_en cycle the two integrators advance and a new
// pulse-density bit is registered on dout. This bit drives the DAC pin
// through an external RC filter.
//
// Ports:
//   clk       system clock (100 MHz)
//   rst       asynchronous reset, active low
//   sample_en single-cycle strobe, din valid this cycle
//   din       signed input sample, DATA_WIDTH bits
//   mod_en    modulator update strobe (oversampling rate, may be tied high)
//   dout      registered 1-bit modulated stream
//   overload  sticky flag, set once either integrator has saturated

module dsm_mod2 #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 20,    // must be >= DATA_WIDTH+3
   parameter int LIMIT      = 24576  // input clamp magnitude (0.75 FS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_en,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         mod_en,
   output logic                         dout,
   output logic                         overload
);

   // Two guard bits cover the worst-case integrator sum before saturation.
   localparam int SW = ACC_WIDTH + 2;

   localparam logic signed [DATA_WIDTH-1:0] LIM_POS = DATA_WIDTH'(LIMIT);
   localparam logic signed [DATA_WIDTH-1:0] LIM_NEG = -LIM_POS;

   // Feedback magnitude FS = 2^(DATA_WIDTH-1). It is zero-extended into the
   // wide domain, so it stays positive there.
   localparam logic signed [SW-1:0] FS_EXT =
      {{(SW-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Symmetric saturation bounds: +/-(2^(ACC_WIDTH-1)-1).
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = -ACC_MAX;
   localparam logic signed [SW-1:0]        SAT_MAX = {2'b00, ACC_MAX};
   localparam logic signed [SW-1:0]        SAT_MIN = -SAT_MAX;

   logic signed [DATA_WIDTH-1:0] x_hold;
   logic signed [DATA_WIDTH-1:0] x_clamp;
   logic signed [ACC_WIDTH-1:0]  i1;
   logic signed [ACC_WIDTH-1:0]  i2;
   logic signed [ACC_WIDTH-1:0]  i1n;
   logic signed [ACC_WIDTH-1:0]  i2n;
   logic signed [SW-1:0]         v;
   logic signed [SW-1:0]         s1;
   logic signed [SW-1:0]         s2;
   logic                         clip1;
   logic                         clip2;

   function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] s);
      if (s > SAT_MAX) begin
         sat = ACC_MAX;
      end else if (s < SAT_MIN) begin
         sat = ACC_MIN;
      end else begin
         sat = s[ACC_WIDTH-1:0];
      end
   endfunction

   // Input clamp to [-LIMIT, +LIMIT].
   // NOTE: every always_comb output is assigned on every path; a missing
   // branch would infer a latch.
   always_comb begin
      x_clamp = din;
      if (din > LIM_POS) begin
         x_clamp = LIM_POS;
      end else if (din < LIM_NEG) begin
         x_clamp = LIM_NEG;
      end
   end

   // Loop arithmetic. The feedback v comes from the registered dout.
   // The second integrator consumes the new i1 value (i1n), not the old one.
   always_comb begin
      v     = dout ? FS_EXT : -FS_EXT;
      s1    = SW'(i1) + SW'(x_hold) - v;
      clip1 = (s1 > SAT_MAX) || (s1 < SAT_MIN);
      i1n   = sat(s1);
      s2    = SW'(i2) + SW'(i1n) - (v <<< 1);
      clip2 = (s2 > SAT_MAX) || (s2 < SAT_MIN);
      i2n   = sat(s2);
   end

   // A sample_en that coincides with mod_en updates x_hold at the same edge.
   // The loop therefore still sees the previous sample on that cycle.
   // NOTE: state registers use non-blocking assignments, so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: this design has no memories; every register is cleared by the
   // asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_hold   <= '0;
         i1       <= '0;
         i2       <= '0;
         dout     <= 1'b0;
         overload <= 1'b0;
      end else begin
         if (sample_en) begin
            x_hold <= x_clamp;
         end
         if (mod_en) begin
            i1   <= i1n;
            i2   <= i2n;
            dout <= ~i2n[ACC_WIDTH-1];  // i2n >= 0, zero maps to 1
            if (clip1 || clip2) begin
               overload <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dsm_mod2.sv
// tb_dsm_mod2 -- scoreboard bench for dsm_mod2.
//
// The stimulus process drives inputs on the falling edge. On every mod_en
// cycle it pushes the expected dout/overload, taken either from a
// hand-computed vector or from a small reference model.
// The monitor process samples on each rising edge (+1) and handles each
// mod_en edge. It pops one entry per edge, compares it, and counts ones
// for the density checks. On edges without mod_en it checks that the
// outputs held. A second instance (ACC_WIDTH=18, LIMIT=32767) shares the
// stimulus and is used for the overload and asynchronous reset checks.

module tb_dsm_mod2;

   localparam longint FS   = 32768;
   localparam longint LIM  = 24576;
   localparam longint SATM = (longint'(1) << 19) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               sample_en = 1'b0;
   logic               mod_en = 1'b0;
   logic signed [15:0] din = '0;
   logic               dout, overload;
   logic               dout5, overload5;

   always #5 clk = ~clk;

   dsm_mod2 dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .din(din),
      .mod_en(mod_en), .dout(dout), .overload(overload)
   );

   dsm_mod2 #(.DATA_WIDTH(16), .ACC_WIDTH(18), .LIMIT(32767)) dut5 (
      .clk(clk), .rst(rst), .sample_en(sample_en), .din(din),
      .mod_en(mod_en), .dout(dout5), .overload(overload5)
   );

   typedef struct {
      bit d;
      bit o;
      int tag;
   } exp_t;

   exp_t   exp_q[$];
   int     n_tests  = 0;
   int     n_fail   = 0;
   int     ones_cnt = 0;
   int     cur_tag  = 0;

   // reference model state
   longint m_i1, m_i2, m_x;
   bit     m_dout, m_ovl;

   task automatic check(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_rng(input string name, input longint act,
                            input longint lo, input longint hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic model_reset();
      m_i1 = 0; m_i2 = 0; m_x = 0; m_dout = 1'b0; m_ovl = 1'b0;
   endtask

   // One clock of stimulus. A non-negative 'hand' replaces the model's dout
   // with a hand-computed expectation.
   task automatic tick(input bit se, input logic signed [15:0] d, input bit me,
                       input int hand = -1);
      longint v, a1, a2, dd;
      bit     hit;
      exp_t   e;
      @(negedge clk);
      sample_en = se;
      din       = d;
      mod_en    = me;
      if (me) begin
         hit = 1'b0;
         v   = m_dout ? FS : -FS;
         a1  = m_i1 + m_x - v;
         if (a1 > SATM) begin a1 = SATM; hit = 1'b1; end
         else if (a1 < -SATM) begin a1 = -SATM; hit = 1'b1; end
         a2  = m_i2 + a1 - 2 * v;
         if (a2 > SATM) begin a2 = SATM; hit = 1'b1; end
         else if (a2 < -SATM) begin a2 = -SATM; hit = 1'b1; end
         m_i1   = a1;
         m_i2   = a2;
         m_dout = (a2 >= 0);
         if (hit) m_ovl = 1'b1;
         e.d   = (hand < 0) ? m_dout : (hand != 0);
         e.o   = m_ovl;
         e.tag = cur_tag;
         exp_q.push_back(e);
      end
      if (se) begin
         dd = d;
         if (dd > LIM) m_x = LIM;
         else if (dd < -LIM) m_x = -LIM;
         else m_x = dd;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; sample_en = 1'b0; mod_en = 1'b0; din = '0;
      #1;
      check("rst_dout", dout, 0);
      check("rst_overload", overload, 0);
      check("rst_dout5", dout5, 0);
      check("rst_overload5", overload5, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   // Latch d, run n mod_en cycles and check the ones count is within [lo, hi].
   task automatic run_density(input string name, input logic signed [15:0] d,
                              input int n, input int lo, input int hi);
      int s0;
      do_reset();
      tick(1'b1, d, 1'b0);
      s0 = ones_cnt;
      for (int i = 0; i < n; i++) tick(1'b0, d, 1'b1);
      tick(1'b0, d, 1'b0);
      check_rng(name, ones_cnt - s0, lo, hi);
      check({name, "_ovl"}, overload, 0);
   endtask

   // Monitor
   initial begin
      bit   me, rs;
      bit   last_d, last_o;
      exp_t e;
      last_d = 1'b0;
      last_o = 1'b0;
      forever begin
         @(posedge clk);
         me = mod_en;
         rs = rst;
         #1;
         if (!rs || !rst) begin
            last_d = 1'b0;
            last_o = 1'b0;
         end else if (me) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow: DUT stepped, nothing expected");
            end else begin
               e = exp_q.pop_front();
               check($sformatf("t%0d_dout", e.tag), dout, e.d);
               check($sformatf("t%0d_ovl", e.tag), overload, e.o);
               last_d = e.d;
               last_o = e.o;
               if (dout) ones_cnt++;
            end
         end else begin
            check("hold_dout", dout, last_d);
            check("hold_ovl", overload, last_o);
         end
      end
   end

   // Stimulus
   initial begin
      bit     hand_seq[8];
      int     sine_tab[50];
      real    r;
      int     snap, k, ones, drops;
      bit     seen;
      longint err;
      logic signed [15:0] d;

      hand_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 50; i++) begin
         r = 16384.0 * $sin(2.0 * 3.14159265358979 * i / 50.0);
         sine_tab[i] = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
      end
      model_reset();

      // Test 1: zero input, hand-computed first 8 bits
      cur_tag = 1;
      do_reset();
      for (int i = 0; i < 8; i++) tick(i == 0, 16'sd0, 1'b1, int'(hand_seq[i]));
      tick(1'b0, 16'sd0, 1'b0);
      check("t1_overload", overload, 0);

      // Test 2/3: DC densities
      cur_tag = 2;
      run_density("t2_half", 16'sd16384, 4096, 3064, 3080);
      cur_tag = 3;
      run_density("t3_pos_clamp", 16'sd32767, 4096, 3576, 3592);
      run_density("t3_neg_clamp", -16'sd32768, 4096, 504, 520);

      // Test 4: mod_en every 2nd cycle, sample_en every 100th, sine input
      cur_tag = 4;
      do_reset();
      snap = 0;
      for (int t = 0; t <= 5102; t++) begin
         d = 16'(sine_tab[(t / 100) % 50]);
         tick((t % 100 == 0) && (t < 5000), d, (t % 2 == 0));
         if (t % 100 == 2) begin
            if (t >= 102) begin
               ones = ones_cnt - snap;
               err  = longint'(ones) * 2 * FS
                      - 50 * (longint'(sine_tab[((t - 102) / 100) % 50]) + FS);
               check_rng($sformatf("t4_density_w%0d", (t - 102) / 100), err, -5 * FS, 5 * FS);
            end
            snap = ones_cnt;
         end
      end

      // Test 5: narrow-integrator instance overloads and stays overloaded
      cur_tag = 5;
      do_reset();
      seen  = 1'b0;
      drops = 0;
      for (int i = 0; i < 4096; i++) begin
         tick(i == 0, 16'sd32767, 1'b1);
         if (overload5) seen = 1'b1;
         else if (seen) drops++;
      end
      tick(1'b0, 16'sd32767, 1'b0);
      if (overload5) seen = 1'b1;
      else if (seen) drops++;
      check("t5_ovl_set", seen, 1);
      check("t5_ovl_sticky", drops, 0);

      k = 0;
      while (dout5 !== 1'b1 && k < 16) begin
         tick(1'b0, 16'sd32767, 1'b1);
         tick(1'b0, 16'sd32767, 1'b0);
         k++;
      end
      check("t5_pre_dout5", dout5, 1);

      // Reset pulse mid-cycle; outputs must clear before the next edge
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("t5_async_dout5", dout5, 0);
      check("t5_async_ovl5", overload5, 0);
      check("t5_async_i1", dut5.i1, 0);
      check("t5_async_i2", dut5.i2, 0);
      check("t5_async_dout", dout, 0);
      check("t5_async_ovl", overload, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      for (int i = 0; i < 64; i++) tick(i == 0, 16'sd32767, 1'b1);
      tick(1'b0, 16'sd0, 1'b0);

      // Test 6: random strobes and samples against the model
      cur_tag = 6;
      for (int i = 0; i < 20000; i++) begin
         d = 16'($urandom);
         tick($urandom_range(0, 7) == 0, d, $urandom_range(0, 1) == 1);
      end

      tick(1'b0, 16'sd0, 1'b0);
      tick(1'b0, 16'sd0, 1'b0);
      check("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
